// File: rtl/mp3_if.sv
// mp3_if: groups the icache, dcache, memory-burst and counter signals of the mp3 memory-side top.
interface mp3_if;
   logic [31:0]  i_addr;
   logic         i_read;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic [31:0]  d_addr;
   logic         d_read;
   logic         d_write;
   logic [255:0] d_wdata;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic [63:0]  burst_o;
   logic [63:0]  burst_i;
   logic         resp_i;
   logic [31:0]  rd_count;
   logic [31:0]  wr_count;
   modport slave (
      input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, burst_i, resp_i,
      output i_rdata, i_resp, d_rdata, d_resp, address_o, read_o, write_o, burst_o,
             rd_count, wr_count
   );
   modport master (
      output i_addr, i_read, d_addr, d_read, d_write, d_wdata, burst_i, resp_i,
      input  i_rdata, i_resp, d_rdata, d_resp, address_o, read_o, write_o, burst_o,
             rd_count, wr_count
   );
endinterface

// File: rtl/mp3_top.sv
// mp3_top: round-robin arbiter turning icache/dcache 256-bit line requests into 4-beat 64-bit memory bursts.
module mp3_top (
   input logic  clk,
   input logic  rst,
   mp3_if.slave bus
);
   localparam int BURST_W = 64;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t       r_state, w_next;
   logic [1:0]   r_k;
   logic         r_gnt_d, r_last_d, r_wr;
   logic [31:0]  r_addr, r_rd_count, r_wr_count;
   logic [255:0] r_line, r_i_rdata, r_d_rdata;
   logic         w_d_pend, w_i_pend, w_gnt_d, w_grant, w_last_beat;
   logic [31:0]  w_addr;
   assign w_d_pend    = bus.d_read | bus.d_write;
   assign w_i_pend    = bus.i_read;
   assign w_grant     = w_d_pend | w_i_pend;
   // on a tie the requester that was not served last wins
   assign w_gnt_d     = w_d_pend & (~w_i_pend | ~r_last_d);
   assign w_addr      = (w_gnt_d ? bus.d_addr : bus.i_addr) & ~32'h1f;
   assign w_last_beat = bus.resp_i & (r_k == 2'd3);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:        w_next = w_grant ? ((w_gnt_d & bus.d_write) ? WRITE : READ) : IDLE;
         READ, WRITE: w_next = w_last_beat ? DONE : r_state;
         default:     w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_k        <= 2'd0;
         r_gnt_d    <= 1'b0;
         r_last_d   <= 1'b0;
         r_wr       <= 1'b0;
         r_addr     <= '0;
         r_line     <= '0;
         r_i_rdata  <= '0;
         r_d_rdata  <= '0;
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_grant) begin
            r_gnt_d <= w_gnt_d;
            r_wr    <= w_gnt_d & bus.d_write;
            r_addr  <= w_addr;
            if (w_gnt_d & bus.d_write) r_line <= bus.d_wdata;
         end
         if ((r_state == READ || r_state == WRITE) && bus.resp_i) r_k <= r_k + 2'd1;
         if (r_state == READ && bus.resp_i) r_line[r_k*BURST_W +: BURST_W] <= bus.burst_i;
         // the final beat is the top quarter, so the full line is visible during DONE
         if (r_state == READ && w_last_beat && r_gnt_d) r_d_rdata <= {bus.burst_i, r_line[191:0]};
         if (r_state == READ && w_last_beat && !r_gnt_d) r_i_rdata <= {bus.burst_i, r_line[191:0]};
         if (r_state == DONE) begin
            r_last_d   <= r_gnt_d;
            r_k        <= 2'd0;
            r_rd_count <= r_wr ? r_rd_count : r_rd_count + 32'd1;
            r_wr_count <= r_wr ? r_wr_count + 32'd1 : r_wr_count;
         end
      end
   end
   assign bus.read_o    = r_state == READ;
   assign bus.write_o   = r_state == WRITE;
   assign bus.i_resp    = r_state == DONE && !r_gnt_d;
   assign bus.d_resp    = r_state == DONE && r_gnt_d;
   assign bus.address_o = r_addr;
   assign bus.burst_o   = (r_state == WRITE) ? r_line[r_k*BURST_W +: BURST_W] : '0;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.rd_count  = r_rd_count;
   assign bus.wr_count  = r_wr_count;
endmodule

// File: tb/tb_mp3_top.sv
// tb_mp3_top: directed and randomized line transfers checked against a transaction-level model of the arbiter.
module tb_mp3_top;
   logic clk = 1'b0;
   logic rst;
   int total = 0;
   int bad = 0;
   logic [31:0]  rd_m, wr_m;
   logic         last_d_m;
   logic [255:0] i_line_m, d_line_m;
   mp3_if bus();
   mp3_top dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [255:0] rnd_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction
   // round-robin: on a tie, whoever was not served last goes first
   function automatic logic pick_d(input logic pi, input logic pd);
      if (pi && pd) return !last_d_m;
      return pd;
   endfunction
   // one line transfer, called at the negedge on which the request became visible to an IDLE arbiter
   task automatic xfer(input logic is_d, input logic is_wr, input logic [31:0] addr,
                       input logic [255:0] line, input logic [7:0] stall);
      int n = 0;
      int k = 0;
      int cyc = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.read_o || bus.write_o) && n < 20);
      chk("grant_latency", n, 1);
      chk("read_o", bus.read_o, !is_wr);
      chk("write_o", bus.write_o, is_wr);
      chk("address_o", bus.address_o, addr & ~32'h1f);
      if (is_d) bus.d_addr = $urandom; else bus.i_addr = $urandom;
      if (is_wr) bus.d_wdata = rnd_line();
      while (k < 4 && cyc < 40) begin
         chk("strobe_held", is_wr ? bus.write_o : bus.read_o, 1);
         if (cyc < 8 && stall[cyc]) begin
            bus.resp_i  = 1'b0;
            bus.burst_i = {$urandom, $urandom};
         end else begin
            bus.resp_i  = 1'b1;
            bus.burst_i = is_wr ? {$urandom, $urandom} : line[k*64 +: 64];
            if (is_wr) chk("burst_o", bus.burst_o, line[k*64 +: 64]);
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.resp_i = 1'($urandom_range(0, 1));
      chk("i_resp", bus.i_resp, !is_d);
      chk("d_resp", bus.d_resp, is_d);
      chk("strobes_done", {bus.read_o, bus.write_o}, 2'b00);
      chk("address_held", bus.address_o, addr & ~32'h1f);
      if (!is_wr) begin
         if (is_d) d_line_m = line; else i_line_m = line;
      end
      chk("i_rdata", bus.i_rdata, i_line_m);
      chk("d_rdata", bus.d_rdata, d_line_m);
      if (is_wr) wr_m++; else rd_m++;
      last_d_m = is_d;
      if (is_d) begin
         bus.d_read  = 1'b0;
         bus.d_write = 1'b0;
      end else bus.i_read = 1'b0;
      @(negedge clk);
      bus.resp_i = 1'b0;
      chk("resp_pulse_end", {bus.i_resp, bus.d_resp}, 2'b00);
      chk("rd_count", bus.rd_count, rd_m);
      chk("wr_count", bus.wr_count, wr_m);
   endtask
   task automatic tie_pair();
      logic [31:0] ia, da;
      ia = $urandom;
      da = $urandom;
      bus.i_addr = ia;
      bus.d_addr = da;
      bus.i_read = 1'b1;
      bus.d_read = 1'b1;
      xfer(1'b1, 1'b0, da, rnd_line(), 8'h00);
      xfer(1'b0, 1'b0, ia, rnd_line(), 8'h00);
   endtask
   initial begin
      logic [255:0] li, ld;
      logic [31:0]  ia, da;
      logic         dw, wd;
      int           kind;
      bus.i_addr = '0; bus.i_read = 1'b0; bus.d_addr = '0; bus.d_read = 1'b0;
      bus.d_write = 1'b0; bus.d_wdata = '0; bus.burst_i = '0; bus.resp_i = 1'b0;
      rd_m = 0; wr_m = 0; last_d_m = 1'b0; i_line_m = '0; d_line_m = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_strobes", {bus.read_o, bus.write_o, bus.i_resp, bus.d_resp}, 4'b0);
      chk("rst_address", bus.address_o, 32'h0);
      chk("rst_burst", bus.burst_o, 64'h0);
      chk("rst_counts", {bus.rd_count, bus.wr_count}, 64'h0);
      chk("rst_i_rdata", bus.i_rdata, 256'h0);
      chk("rst_d_rdata", bus.d_rdata, 256'h0);
      tie_pair();
      tie_pair();
      bus.i_addr = 32'h0000_1234;
      bus.i_read = 1'b1;
      xfer(1'b0, 1'b0, 32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 8'h00);
      chk("icache_line", bus.i_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
      ld = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
      bus.d_addr = 32'h8000_0040;
      bus.d_wdata = ld;
      bus.d_write = 1'b1;
      xfer(1'b1, 1'b1, 32'h8000_0040, ld, 8'h00);
      bus.i_addr = 32'h0000_5678;
      bus.i_read = 1'b1;
      xfer(1'b0, 1'b0, 32'h0000_5678, rnd_line(), 8'b0010_0110);
      ld = rnd_line();
      bus.d_addr = 32'h0000_9abc;
      bus.d_wdata = ld;
      bus.d_read = 1'b1;
      bus.d_write = 1'b1;
      xfer(1'b1, 1'b1, 32'h0000_9abc, ld, 8'h00);
      bus.resp_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stray_resp_strobes", {bus.read_o, bus.write_o, bus.i_resp, bus.d_resp}, 4'b0);
         chk("stray_resp_counts", {bus.rd_count, bus.wr_count}, {rd_m, wr_m});
      end
      bus.resp_i = 1'b0;
      bus.d_addr = 32'h0000_0100;
      bus.d_read = 1'b1;
      xfer(1'b1, 1'b0, 32'h0000_0100, rnd_line(), 8'h00);
      for (int t = 0; t < 24; t++) begin
         kind = $urandom_range(0, 3);
         ia = $urandom;
         da = $urandom;
         li = rnd_line();
         ld = rnd_line();
         dw = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
         bus.i_addr = ia;
         bus.d_addr = da;
         bus.d_wdata = ld;
         bus.i_read = (kind == 0) || (kind == 3);
         bus.d_read = (kind == 1) || (kind == 3 && !dw);
         bus.d_write = dw;
         if (kind == 3) begin
            wd = pick_d(1'b1, 1'b1);
            if (wd) begin
               xfer(1'b1, dw, da, ld, 8'($urandom_range(0, 255)));
               xfer(1'b0, 1'b0, ia, li, 8'($urandom_range(0, 255)));
            end else begin
               xfer(1'b0, 1'b0, ia, li, 8'($urandom_range(0, 255)));
               xfer(1'b1, dw, da, ld, 8'($urandom_range(0, 255)));
            end
         end else if (kind == 0) xfer(1'b0, 1'b0, ia, li, 8'($urandom_range(0, 255)));
         else xfer(1'b1, dw, da, ld, 8'($urandom_range(0, 255)));
      end
      bus.i_addr = $urandom;
      bus.i_read = 1'b1;
      @(negedge clk);
      chk("pre_reset_read_o", bus.read_o, 1'b1);
      bus.resp_i = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      @(negedge clk);
      rst = 1'b0;
      bus.i_read = 1'b0;
      bus.resp_i = 1'b0;
      #1;
      rd_m = 0; wr_m = 0; last_d_m = 1'b0; i_line_m = '0; d_line_m = '0;
      chk("async_rst_read_o", bus.read_o, 1'b0);
      chk("async_rst_counts", {bus.rd_count, bus.wr_count}, 64'h0);
      chk("async_rst_address", bus.address_o, 32'h0);
      chk("async_rst_rdata", {bus.i_rdata, bus.d_rdata}, 512'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {bus.read_o, bus.write_o}, 2'b00);
      tie_pair();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
